// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file of the mips32 pipeline.
// Selects ALU/load/link writeback data and serves two bypassed decode read ports.
module wb_regfile #(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:2]           controlIn,
  input  logic [2:0]           ldType,
  input  logic [DATA_W-1:0]    pcIn,
  input  logic [DATA_W-1:0]    memDataIn,
  input  logic [DATA_W-1:0]    aluResultIn,
  input  logic [NREG_LOG2-1:0] destRegIn,
  input  logic [NREG_LOG2-1:0] rs1Addr,
  input  logic [NREG_LOG2-1:0] rs2Addr,
  output logic [DATA_W-1:0]    rs1Data,
  output logic [DATA_W-1:0]    rs2Data,
  output logic [DATA_W-1:0]    wbData,
  output logic [NREG_LOG2-1:0] wbReg,
  output logic                 wbEn
);

  localparam int NREG = 1 << NREG_LOG2;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic              regWrite;
  logic [1:0]        wbSel;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [DATA_W-1:0] loadValue;
  logic [DATA_W-1:0] linkAddr;
  logic [DATA_W-1:0] wbData_d;
  logic [DATA_W-1:0] regFile_q [NREG];

  assign regWrite = controlIn[0];
  assign wbSel    = controlIn[1:2];
  assign linkAddr = pcIn + DATA_W'(8);

  // Big-endian lane select: byte offset 0 is the most significant byte.
  always_comb begin
    loadByte = memDataIn[31:24];
    case (aluResultIn[1:0])
      2'd0: loadByte = memDataIn[31:24];
      2'd1: loadByte = memDataIn[23:16];
      2'd2: loadByte = memDataIn[15:8];
      2'd3: loadByte = memDataIn[7:0];
      default: loadByte = memDataIn[31:24];
    endcase
  end

  assign loadHalf = aluResultIn[1] ? memDataIn[15:0] : memDataIn[31:16];

  always_comb begin
    loadValue = memDataIn;
    case (ldType)
      LD_LH:   loadValue = {{(DATA_W-16){loadHalf[15]}}, loadHalf};
      LD_LHU:  loadValue = {{(DATA_W-16){1'b0}}, loadHalf};
      LD_LB:   loadValue = {{(DATA_W-8){loadByte[7]}}, loadByte};
      LD_LBU:  loadValue = {{(DATA_W-8){1'b0}}, loadByte};
      default: loadValue = memDataIn;
    endcase
  end

  always_comb begin
    wbData_d = aluResultIn;
    case (wbSel)
      SEL_MEM:  wbData_d = loadValue;
      SEL_LINK: wbData_d = linkAddr;
      default:  wbData_d = aluResultIn;
    endcase
  end

  assign wbData = wbData_d;
  assign wbReg  = destRegIn;
  // Held low during reset so nothing is bypassed or written while rst is asserted.
  assign wbEn   = regWrite && (destRegIn != '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (wbEn) begin
      regFile_q[destRegIn] <= wbData_d;
    end
  end

  // Register 0 reads as zero regardless of storage; same-cycle writes bypass.
  always_comb begin
    rs1Data = regFile_q[rs1Addr];
    if (rs1Addr == '0) begin
      rs1Data = '0;
    end else if (wbEn && (rs1Addr == destRegIn)) begin
      rs1Data = wbData_d;
    end
  end

  always_comb begin
    rs2Data = regFile_q[rs2Addr];
    if (rs2Addr == '0) begin
      rs2Data = '0;
    end else if (wbEn && (rs2Addr == destRegIn)) begin
      rs2Data = wbData_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:2]  controlIn = '0;
  logic [2:0]  ldType = '0;
  logic [31:0] pcIn = '0;
  logic [31:0] memDataIn = '0;
  logic [31:0] aluResultIn = '0;
  logic [4:0]  destRegIn = '0;
  logic [4:0]  rs1Addr = '0;
  logic [4:0]  rs2Addr = '0;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] wbData;
  logic [4:0]  wbReg;
  logic        wbEn;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32] = '{default: 32'h0};

  wb_regfile #(.DATA_W(32), .NREG_LOG2(5)) dut (
    .clk(clk), .rst(rst), .controlIn(controlIn), .ldType(ldType),
    .pcIn(pcIn), .memDataIn(memDataIn), .aluResultIn(aluResultIn),
    .destRegIn(destRegIn), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .wbData(wbData),
    .wbReg(wbReg), .wbEn(wbEn)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback value derived directly from the load/link rules.
  function automatic logic [31:0] modelWbData();
    logic [1:0]  sel;
    int unsigned byteVal, halfVal, offset;
    sel = {controlIn[1], controlIn[2]};
    if (sel == 2'b10) return pcIn + 32'd8;
    if (sel != 2'b01) return aluResultIn;
    offset  = aluResultIn[1:0];
    byteVal = (memDataIn >> (8 * (3 - offset))) & 32'hFF;
    halfVal = aluResultIn[1] ? (memDataIn & 32'hFFFF) : (memDataIn >> 16);
    case (ldType)
      3'd1: return (halfVal >= 32'h8000) ? halfVal + 32'hFFFF0000 : halfVal;
      3'd2: return halfVal;
      3'd3: return (byteVal >= 32'h80) ? byteVal + 32'hFFFFFF00 : byteVal;
      3'd4: return byteVal;
      default: return memDataIn;
    endcase
  endfunction

  function automatic logic modelWbEn();
    return !rst && controlIn[0] && (destRegIn != 5'd0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] addr);
    if (rst || addr == 5'd0) return 32'h0;
    if (modelWbEn() && addr == destRegIn) return modelWbData();
    return model[addr];
  endfunction

  // Reference register contents: cleared by reset, written at the clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (modelWbEn()) begin
      model[destRegIn] = modelWbData();
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    checkOutput("wbData", wbData, modelWbData());
    checkOutput("wbEn", {31'h0, wbEn}, {31'h0, modelWbEn()});
    checkOutput("wbReg", {27'h0, wbReg}, {27'h0, destRegIn});
    checkOutput("rs1Data", rs1Data, modelRead(rs1Addr));
    checkOutput("rs2Data", rs2Data, modelRead(rs2Addr));
  end

  task automatic applyStimulus(input logic rw, input logic [1:0] sel, input logic [2:0] ld,
                               input logic [31:0] pc, input logic [31:0] mem,
                               input logic [31:0] alu, input logic [4:0] dest,
                               input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    controlIn   = {rw, sel};
    ldType      = ld;
    pcIn        = pc;
    memDataIn   = mem;
    aluResultIn = alu;
    destRegIn   = dest;
    rs1Addr     = a1;
    rs2Addr     = a2;
    #1;
  endtask

  logic [2:0]  loadTypes [7] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd1, 3'd2, 3'd0};
  logic [31:0] loadAddrs [7] = '{32'h0, 32'h0, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0};
  logic [31:0] loadExp   [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001, 32'h00007F01,
                                 32'hFFFF80F1, 32'h000080F1, 32'h80F17F01};

  initial begin
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0);
    checkOutput("rstHeldNoBypass", rs1Data, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("bypassR5", rs1Data, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd0);
    checkOutput("storedR5", rs1Data, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    checkOutput("asyncResetR5", rs1Data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
    end

    applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 32'h0, 32'h12345678, 5'd7, 5'd7, 5'd7);
    checkOutput("bypassRs1", rs1Data, 32'h12345678);
    checkOutput("bypassRs2", rs2Data, 32'h12345678);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    checkOutput("storedR7", rs1Data, 32'h12345678);

    applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    checkOutput("r0WbEn", {31'h0, wbEn}, 32'h0);
    checkOutput("r0Read", rs1Data, 32'h0);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkOutput("r0AfterEdge", rs1Data, 32'h0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 2'b01, loadTypes[i], 32'h0, 32'h80F17F01, loadAddrs[i], 5'd10, 5'd10, 5'd0);
      checkOutput($sformatf("load%0d", i), wbData, loadExp[i]);
    end

    applyStimulus(1'b1, 2'b10, 3'd0, 32'h00400010, 32'h0, 32'h0, 5'd31, 5'd31, 5'd0);
    checkOutput("linkBypass", rs1Data, 32'h00400018);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd31, 5'd0);
    checkOutput("linkStored", rs1Data, 32'h00400018);
    applyStimulus(1'b1, 2'b10, 3'd0, 32'hFFFFFFF8, 32'h0, 32'h0, 5'd31, 5'd31, 5'd0);
    checkOutput("linkWrap", wbData, 32'h0);

    applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 32'h0, 32'h11, 5'd3, 5'd0, 5'd3);
    checkOutput("b2bFirst", rs2Data, 32'h11);
    applyStimulus(1'b1, 2'b00, 3'd0, 32'h0, 32'h0, 32'h22, 5'd3, 5'd0, 5'd3);
    checkOutput("b2bSecond", rs2Data, 32'h22);
    applyStimulus(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd3);
    checkOutput("b2bHeld", rs2Data, 32'h22);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] dest, a1, a2;
      dest = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    dest, a1, a2);
      rst = ($urandom_range(0, 99) < 3);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
